// File: rtl/ser_bin2bcd.sv
// Serial double-dabble binary-to-BCD converter fed MSB-first, one bit per clock.
// Define SER_BIN2BCD_OVF_EN to add a sticky ovf output for truncated results.
module ser_bin2bcd #(
  parameter int WORD_LENGTH = 8,
  parameter int BCD_DIGITS  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    ser_in,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    valid,
  output logic                    busy
`ifdef SER_BIN2BCD_OVF_EN
  ,
  output logic                    ovf
`endif
);

  localparam int BW = 4 * BCD_DIGITS;
  localparam int CW = $clog2(WORD_LENGTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   work_q, work_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;

  logic [BW-1:0]   step_src;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   step;

`ifdef SER_BIN2BCD_OVF_EN
  logic            flag_q, flag_d;
  logic            ovf_q, ovf_d;
`else
  logic            unused_top;
  assign unused_top = adj[BW-1];
`endif

  // The register starts empty on an accepted start, so the first bit dabbles against zero.
  always_comb begin
    step_src = (state_q == IDLE) ? '0 : work_q;
    adj      = step_src;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (step_src[4*i +: 4] >= 4'd5) adj[4*i +: 4] = step_src[4*i +: 4] + 4'd3;
    end
    step = {adj[BW-2:0], ser_in};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
`ifdef SER_BIN2BCD_OVF_EN
    flag_d  = flag_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = step;
          cnt_d   = CW'(1);
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef SER_BIN2BCD_OVF_EN
          flag_d  = 1'b0;
`endif
        end
      end
      SHIFT: begin
        work_d = step;
        cnt_d  = cnt_q + 1'b1;
`ifdef SER_BIN2BCD_OVF_EN
        flag_d = flag_q | adj[BW-1];
`endif
        if (cnt_q == CW'(WORD_LENGTH - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          bcd_d   = step;
`ifdef SER_BIN2BCD_OVF_EN
          ovf_d   = flag_q | adj[BW-1];
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SER_BIN2BCD_OVF_EN
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef SER_BIN2BCD_OVF_EN
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bcd   = bcd_q;
  assign valid = valid_q;
  assign busy  = busy_q;
`ifdef SER_BIN2BCD_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule
